// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with modulus, load,
// wrap/saturate modes, terminal count, wrap pulse and sticky overflow.
module sync_updown_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MOD_MAX = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] load_clamp;
  logic             wrap_nx;
  logic             ovf_nx;
  logic             step;
  logic             at_max;
  logic             at_min;

  assign at_max = (count == MOD_MAX);
  assign at_min = (count == '0);
  assign tc     = up_dn ? at_max : at_min;
  assign step   = en && !load;

  assign load_clamp = (load_val > MOD_MAX) ? MOD_MAX
                                           : load_val;

  // Arms are mutually exclusive so load priority is explicit
  always_comb begin
    count_nx = count;
    wrap_nx  = 1'b0;
    ovf_nx   = ovf && !ovf_clr;
    unique case (1'b1)
      load: begin
        count_nx = load_clamp;
      end
      step && !tc: begin
        count_nx = up_dn ? count + 1'b1
                         : count - 1'b1;
      end
      step && tc && !sat_mode: begin
        count_nx = up_dn ? '0 : MOD_MAX;
        wrap_nx  = 1'b1;
        ovf_nx   = 1'b1;
      end
      step && tc && sat_mode: begin
        ovf_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nx;
      wrap  <= wrap_nx;
      ovf   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed vector bench for sync_updown_counter:
// full-range instance (MOD_MAX=15) and a mod-10 instance.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b0;
  logic       sat_mode = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       ovf_clr = 1'b0;

  logic [3:0] c0, c9;
  logic       tc0, tc9;
  logic       w0, w9;
  logic       o0, o9;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4)) u0 (
    .clk(clk), .rst(rst), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr),
    .count(c0), .tc(tc0), .wrap(w0), .ovf(o0)
  );

  sync_updown_counter #(
    .WIDTH(4), .MOD_MAX(4'd9)
  ) u9 (
    .clk(clk), .rst(rst), .en(en),
    .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr),
    .count(c9), .tc(tc9), .wrap(w9), .ovf(o9)
  );

  typedef struct {
    logic       rst, en, up, sat, ld, clr;
    logic [3:0] lv;
    logic [3:0] e_cnt;
    logic       e_tc, e_wrap, e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic r, input logic e, input logic u,
    input logic s, input logic l, input logic [3:0] v,
    input logic c, input logic [3:0] ec,
    input logic et, input logic ew, input logic eo);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.sat = s;
    x.ld = l; x.lv = v; x.clr = c;
    x.e_cnt = ec; x.e_tc = et;
    x.e_wrap = ew; x.e_ovf = eo;
    vq.push_back(x);
  endfunction

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic r, input logic e, input logic u,
    input logic s, input logic l, input logic [3:0] v,
    input logic c);
    rst = r; en = e; up_dn = u; sat_mode = s;
    load = l; load_val = v; ovf_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // args: rst en up sat ld lv clr | cnt tc wrap ovf
    // T1: count up through wrap
    add(1,0,1,0,0,0,0, 0,0,0,0);
    for (int k = 1; k <= 17; k++)
      add(0,1,1,0,0,0,0, 4'(k % 16),
          (k % 16) == 15, k == 16, k >= 16);
    // T2: count down wraps 0 -> 15
    add(1,0,0,0,0,0,0, 0,1,0,0);
    add(0,1,0,0,0,0,0, 15,0,1,1);
    add(0,1,0,0,0,0,0, 14,0,0,1);
    // T3: saturate up, then down
    add(1,0,1,0,0,0,0, 0,0,0,0);
    add(0,0,1,1,1,14,0, 14,0,0,0);
    add(0,1,1,1,0,0,0, 15,1,0,0);
    add(0,1,1,1,0,0,0, 15,1,0,1);
    add(0,1,1,1,0,0,0, 15,1,0,1);
    add(0,0,0,1,1,0,1, 0,1,0,0);
    add(0,1,0,1,0,0,0, 0,1,0,1);
    // T5: rst beats load and en
    add(0,0,1,0,1,7,0, 7,0,0,1);
    add(1,1,1,0,1,9,0, 0,0,0,0);
    // T6: set beats ovf_clr, then clear
    add(0,0,1,0,1,15,0, 15,1,0,0);
    add(0,1,1,0,0,0,1, 0,0,1,1);
    add(0,0,1,0,0,0,1, 0,0,0,0);
    // hold, load ignores en/up_dn
    add(0,1,1,0,0,0,0, 1,0,0,0);
    add(0,0,1,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,1,5,0, 5,0,0,0);
    add(0,1,0,0,0,0,0, 4,0,0,0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].up,
            vq[i].sat, vq[i].ld, vq[i].lv,
            vq[i].clr);
      tick();
      chk($sformatf("v%0d count", i), c0, vq[i].e_cnt);
      chk($sformatf("v%0d tc", i), tc0, vq[i].e_tc);
      chk($sformatf("v%0d wrap", i), w0, vq[i].e_wrap);
      chk($sformatf("v%0d ovf", i), o0, vq[i].e_ovf);
    end

    // mod-10 instance: clamp, wrap, load priority
    drive(1,0,1,0,0,0,0); tick();
    chk("m9 rst count", c9, 0);
    chk("m9 rst tc", tc9, 0);
    drive(0,0,1,0,1,12,0); tick();
    chk("m9 clamp count", c9, 9);
    chk("m9 clamp tc", tc9, 1);
    chk("m9 clamp ovf", o9, 0);
    drive(0,1,1,0,0,0,0); tick();
    chk("m9 wrap count", c9, 0);
    chk("m9 wrap pulse", w9, 1);
    chk("m9 wrap ovf", o9, 1);
    drive(0,1,1,0,1,3,0); tick();
    chk("m9 ld>en count", c9, 3);
    chk("m9 ld>en wrap", w9, 0);
    drive(0,0,0,0,1,0,1); tick();
    chk("m9 ld0 ovf", o9, 0);
    drive(0,1,0,0,0,0,0); tick();
    chk("m9 dn wrap count", c9, 9);
    chk("m9 dn wrap pulse", w9, 1);
    drive(0,1,0,0,0,0,0); tick();
    chk("m9 dn count", c9, 8);
    chk("m9 dn wrap end", w9, 0);
    drive(0,1,1,1,1,15,0); tick();
    drive(0,1,1,1,0,0,0); tick();
    chk("m9 sat count", c9, 9);
    chk("m9 sat wrap", w9, 0);
    drive(0,0,1,0,0,0,0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
